// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester channels and the shared memory port.
// slave is the arbiter's view; master is the view of the requesters plus memory around it.
interface mem_port_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic            m0_valid;
  logic            m0_ready;
  logic [AW-1:0]   m0_addr;
  logic            m0_rvalid;
  logic [DW-1:0]   m0_rdata;
  logic            m0_err;

  logic            m1_valid;
  logic            m1_ready;
  logic [AW-1:0]   m1_addr;
  logic            m1_wen;
  logic [DW-1:0]   m1_wdata;
  logic [DW/8-1:0] m1_wmask;
  logic            m1_rvalid;
  logic [DW-1:0]   m1_rdata;
  logic            m1_err;

  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_wen;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  m0_valid, m0_addr,
    output m0_ready, m0_rvalid, m0_rdata, m0_err,
    input  m1_valid, m1_addr, m1_wen, m1_wdata, m1_wmask,
    output m1_ready, m1_rvalid, m1_rdata, m1_err,
    output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output m0_valid, m0_addr,
    input  m0_ready, m0_rvalid, m0_rdata, m0_err,
    output m1_valid, m1_addr, m1_wen, m1_wdata, m1_wmask,
    input  m1_ready, m1_rvalid, m1_rdata, m1_err,
    input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (m0) and load/store (m1),
// one transaction in flight, with a response watchdog that answers with err instead of hanging.
module mem_port_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int MW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [MW-1:0] wmask_q, wmask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;

  logic          accept_s;
  logic          pick_m1_s;
  logic          resp_fire_s;
  logic          resp_err_s;
  logic [DW-1:0] resp_data_s;
  logic [CW-1:0] cnt_inc_s;

  // Round-robin pick; on a tie the requester that was not granted last wins.
  always_comb begin
    accept_s  = 1'b0;
    pick_m1_s = 1'b0;
    if (rst && (state_q == ST_IDLE)) begin
      if (bus.m0_valid && (!bus.m1_valid || last_grant_q)) begin
        accept_s  = 1'b1;
        pick_m1_s = 1'b0;
      end else if (bus.m1_valid) begin
        accept_s  = 1'b1;
        pick_m1_s = 1'b1;
      end else begin
        accept_s  = 1'b0;
        pick_m1_s = 1'b0;
      end
    end else begin
      accept_s  = 1'b0;
      pick_m1_s = 1'b0;
    end
  end

  // cnt_inc_s counts the current WAIT cycle, so the watchdog fires after TIMEOUT cycles in WAIT.
  assign cnt_inc_s = cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    cnt_d        = cnt_q;
    resp_fire_s  = 1'b0;
    resp_err_s   = 1'b0;
    resp_data_s  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d      = ST_ISSUE;
          grant_d      = pick_m1_s;
          last_grant_d = pick_m1_s;
          addr_d       = pick_m1_s ? bus.m1_addr : bus.m0_addr;
          wen_d        = pick_m1_s & bus.m1_wen;
          wdata_d      = pick_m1_s ? bus.m1_wdata : '0;
          wmask_d      = pick_m1_s ? bus.m1_wmask : '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_ready) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc_s;
        if (bus.mem_rvalid) begin
          state_d     = ST_RESP;
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b0;
          resp_data_s = wen_q ? '0 : bus.mem_rdata;
        end else if (cnt_inc_s == CW'(TIMEOUT)) begin
          state_d     = ST_RESP;
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b1;
          resp_data_s = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Per-requester response registers so each side keeps its own last result.
  always_comb begin
    m0_rdata_d = m0_rdata_q;
    m0_err_d   = m0_err_q;
    m1_rdata_d = m1_rdata_q;
    m1_err_d   = m1_err_q;
    if (resp_fire_s && grant_q) begin
      m1_rdata_d = resp_data_s;
      m1_err_d   = resp_err_s;
    end else if (resp_fire_s) begin
      m0_rdata_d = resp_data_s;
      m0_err_d   = resp_err_s;
    end else begin
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      cnt_q        <= '0;
      m0_rdata_q   <= '0;
      m0_err_q     <= 1'b0;
      m1_rdata_q   <= '0;
      m1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      cnt_q        <= cnt_d;
      m0_rdata_q   <= m0_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_rdata_q   <= m1_rdata_d;
      m1_err_q     <= m1_err_d;
    end
  end

  assign bus.m0_ready  = accept_s & ~pick_m1_s;
  assign bus.m1_ready  = accept_s & pick_m1_s;
  assign bus.m0_rvalid = (state_q == ST_RESP) & ~grant_q;
  assign bus.m1_rvalid = (state_q == ST_RESP) & grant_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m0_err    = m0_err_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.m1_err    = m1_err_q;
  assign bus.mem_valid = (state_q == ST_ISSUE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter; expectations come from a transaction-level
// model (round-robin choice plus arithmetic on issue/response cycle offsets).
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  int          last_grant;
  logic [63:0] exp_rd [2];
  logic        exp_err [2];

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise();
    bus.m0_valid  = 1'($urandom_range(0, 1));
    bus.m1_valid  = 1'($urandom_range(0, 1));
    bus.m0_addr   = {$urandom, $urandom};
    bus.m1_addr   = {$urandom, $urandom};
    bus.m1_wen    = 1'($urandom_range(0, 1));
    bus.m1_wdata  = {$urandom, $urandom};
    bus.m1_wmask  = 8'($urandom);
    bus.mem_rdata = {$urandom, $urandom};
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_rd0"}, bus.m0_rdata, exp_rd[0]);
    chk({tag, "_er0"}, 64'(bus.m0_err), 64'(exp_err[0]));
    chk({tag, "_rd1"}, bus.m1_rdata, exp_rd[1]);
    chk({tag, "_er1"}, 64'(bus.m1_err), 64'(exp_err[1]));
  endtask

  task automatic model_reset();
    last_grant = 1;
    exp_rd[0]  = 64'd0;
    exp_rd[1]  = 64'd0;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
  endtask

  // One transaction: pat 0=m0 only, 1=m1 only, 2=both; d = cycles of mem_ready low;
  // r = WAIT cycle index of mem_rvalid (>= TO means never); rst_at = WAIT cycle to reset in.
  task automatic run_txn(input int pat, input logic [63:0] a0, input logic [63:0] a1,
                         input logic wen1, input logic [63:0] wd1, input logic [7:0] wm1,
                         input int d, input int r, input logic [63:0] rd, input int rst_at);
    int          g;
    logic [63:0] e_addr, e_wdata, e_data;
    logic [7:0]  e_wmask;
    logic        e_wen, e_err;
    g       = (pat == 0) ? 0 : (pat == 1) ? 1 : (1 - last_grant);
    e_addr  = g ? a1 : a0;
    e_wen   = g ? wen1 : 1'b0;
    e_wdata = g ? wd1 : 64'd0;
    e_wmask = g ? wm1 : 8'd0;
    e_data  = 64'd0;
    e_err   = 1'b0;

    rst            = 1'b1;
    bus.m0_valid   = (pat != 1);
    bus.m1_valid   = (pat != 0);
    bus.m0_addr    = a0;
    bus.m1_addr    = a1;
    bus.m1_wen     = wen1;
    bus.m1_wdata   = wd1;
    bus.m1_wmask   = wm1;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("acc_rdy0", 64'(bus.m0_ready), 64'(g == 0));
    chk("acc_rdy1", 64'(bus.m1_ready), 64'(g == 1));
    chk("acc_rv", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
    chk("acc_mv", 64'(bus.mem_valid), 64'd0);
    next_cycle();
    last_grant = g;

    for (int k = 0; k <= d; k++) begin
      drive_noise();
      bus.mem_ready  = (k == d);
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("iss_mv", 64'(bus.mem_valid), 64'd1);
      chk("iss_addr", bus.mem_addr, e_addr);
      chk("iss_wen", 64'(bus.mem_wen), 64'(e_wen));
      chk("iss_wd", bus.mem_wdata, e_wdata);
      chk("iss_wm", 64'(bus.mem_wmask), 64'(e_wmask));
      chk("iss_rdy", 64'({bus.m0_ready, bus.m1_ready, bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
      chk_hold("iss");
      next_cycle();
    end

    for (int j = 0; j < TO; j++) begin
      drive_noise();
      bus.mem_ready  = 1'($urandom_range(0, 1));
      bus.mem_rvalid = (j == r);
      if (j == r) bus.mem_rdata = rd;
      if (j == rst_at) begin
        rst            = 1'b0;
        bus.mem_rvalid = 1'b0;
      end
      @(negedge clk);
      chk("wt_mv", 64'(bus.mem_valid), 64'd0);
      chk("wt_rdy", 64'({bus.m0_ready, bus.m1_ready, bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
      chk_hold("wt");
      next_cycle();
      if (j == rst_at) begin
        model_reset();
        rst            = 1'b1;
        bus.m0_valid   = 1'b0;
        bus.m1_valid   = 1'b0;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rst_rv", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
        chk("rst_mv", 64'(bus.mem_valid), 64'd0);
        chk("rst_addr", bus.mem_addr, 64'd0);
        chk_hold("rst");
        next_cycle();
        return;
      end
      if (j == r) begin
        e_data = (g == 1 && wen1) ? 64'd0 : rd;
        e_err  = 1'b0;
        break;
      end
      if (j == TO - 1) begin
        e_data = 64'd0;
        e_err  = 1'b1;
      end
    end

    exp_rd[g]  = e_data;
    exp_err[g] = e_err;
    drive_noise();
    bus.mem_rvalid = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("rsp_rv0", 64'(bus.m0_rvalid), 64'(g == 0));
    chk("rsp_rv1", 64'(bus.m1_rvalid), 64'(g == 1));
    chk("rsp_rdy", 64'({bus.m0_ready, bus.m1_ready}), 64'd0);
    chk_hold("rsp");
    next_cycle();
  endtask

  task automatic idle_cycle(input logic late_rvalid);
    bus.m0_valid   = 1'b0;
    bus.m1_valid   = 1'b0;
    bus.mem_rvalid = late_rvalid;
    bus.mem_rdata  = {$urandom, $urandom};
    @(negedge clk);
    chk("idl_rv", 64'({bus.m0_rvalid, bus.m1_rvalid, bus.mem_valid}), 64'd0);
    chk_hold("idl");
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst            = 1'b0;
    bus.m0_valid   = 1'b1;
    bus.m1_valid   = 1'b1;
    bus.m0_addr    = 64'h0;
    bus.m1_addr    = 64'h0;
    bus.m1_wen     = 1'b0;
    bus.m1_wdata   = 64'h0;
    bus.m1_wmask   = 8'h0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 64'h0;
    next_cycle();

    for (int i = 0; i < 3; i++) begin
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rdy", 64'({bus.m0_ready, bus.m1_ready}), 64'd0);
      chk("rst_rvl", 64'({bus.m0_rvalid, bus.m1_rvalid, bus.mem_valid}), 64'd0);
      chk("rst_out", bus.mem_addr | bus.mem_wdata | 64'(bus.mem_wmask) | 64'(bus.mem_wen), 64'd0);
      chk_hold("rst0");
      next_cycle();
    end

    // Release with both requesters pending: fetch must win the first tie.
    run_txn(2, 64'h1000, 64'h2000, 1'b0, 64'h0, 8'h0, 0, 0, 64'h55, -1);
    run_txn(0, 64'h8000_0000, 64'h0, 1'b0, 64'h0, 8'h0, 0, 0, 64'h0000_0013, -1);
    for (int i = 0; i < 4; i++)
      run_txn(2, 64'h8000_0000 + 64'(i * 4), 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F,
              0, 0, {$urandom, $urandom}, -1);
    run_txn(1, 64'h0, 64'h8000_2000, 1'b0, 64'h0, 8'h0, 5, 2, 64'hCAFE, -1);
    run_txn(1, 64'h0, 64'h8000_3000, 1'b0, 64'h0, 8'h0, 0, 1000, 64'h1234, -1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    run_txn(0, 64'h40, 64'h0, 1'b0, 64'h0, 8'h0, 1, TO - 1, 64'h77, -1);
    run_txn(2, 64'h50, 64'h60, 1'b0, 64'h0, 8'h0, 0, 1000, 64'h0, 3);
    run_txn(0, 64'h8000_0010, 64'h0, 1'b0, 64'h0, 8'h0, 0, 1, 64'h99, -1);

    for (int i = 0; i < 60; i++) begin
      int rst_at;
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(int'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 2)),
              {$urandom, $urandom}, rst_at);
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port (addr/wen/din/dout class) between two requesters: m0 = instruction fetch, m1 = load/store.
- Each requester has a valid/ready request channel and a one-cycle rvalid response.
- Only one transaction is outstanding at a time. Requesters are granted round-robin.
- A response watchdog returns an error instead of hanging the core.

Parameters:
AW, 64, address width
DW, 64, data width; byte mask width is DW/8
TIMEOUT, 255, max cycles in WAIT before error response; counter width clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
m0_valid  in  1  fetch request valid
m0_ready  out  1  fetch request accepted this cycle
m0_addr  in  AW  fetch address
m0_rvalid  out  1  fetch response, one-cycle pulse
m0_rdata  out  DW  fetch response data
m0_err  out  1  fetch timeout, qualified by m0_rvalid
m1_valid  in  1  load/store request valid
m1_ready  out  1  load/store request accepted
m1_addr  in  AW  load/store address
m1_wen  in  1  1 = store
m1_wdata  in  DW  store data
m1_wmask  in  DW/8  store byte mask
m1_rvalid  out  1  load/store response, one-cycle pulse
m1_rdata  out  DW  load data; 0 for stores
m1_err  out  1  timeout, qualified by m1_rvalid
mem_valid  out  1  memory request valid
mem_ready  in  1  memory accepts request
mem_addr  out  AW  latched address
mem_wen  out  1  latched write enable; always 0 for m0
mem_wdata  out  DW  latched write data
mem_wmask  out  DW/8  latched mask
mem_rvalid  in  1  memory response/write-ack, one cycle
mem_rdata  in  DW  memory read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (rst==0 at posedge): state=IDLE, last_grant=m1 (so m0 wins the first tie), counter=0.
  - All outputs 0: ready, rvalid, err, mem_valid, mem_* data.
  - Reset mid-transaction aborts it silently; no rvalid is issued.
- IDLE:
  - mX_ready is combinational: asserted for the granted requester when its valid=1.
  - Only one requester is accepted, and only in IDLE. ready is 0 in every other state.
  - Grant rules: only m0 valid -> m0; only m1 valid -> m1; both valid -> the one != last_grant.
  - On accept: latch addr/wen/wdata/wmask (m0: wen=0, wdata=0, wmask=0), record grant, update last_grant, go to ISSUE.
- ISSUE:
  - mem_valid=1 with the latched fields, held stable until mem_ready.
  - mem_ready=1 -> WAIT, counter cleared.
  - No timeout in ISSUE.
- WAIT:
  - mem_valid=0; counter increments each cycle.
  - mem_rvalid=1 -> capture rdata (0 if the transaction is a write), err=0, go to RESP. mem_rvalid wins if it coincides with counter==TIMEOUT.
  - Otherwise, counter==TIMEOUT -> rdata=0, err=1, go to RESP.
- RESP:
  - Granted requester's rvalid=1 for exactly one cycle, with registered rdata/err. The other requester sees rvalid=0.
  - Then go to IDLE. A new accept is possible the cycle after RESP.
- mem_rvalid outside WAIT (late response after timeout) is ignored.
- Minimum latency: accept at cycle N, mem_valid at N+1, mem_rvalid at N+2, mX_rvalid at N+3. Back-to-back throughput is one transaction per 4 cycles.
- Requester rules:
  - Requester inputs only need to be held until ready.
  - Deasserting valid before ready is legal; no grant occurs.
  - mX_rdata/err hold their last value while rvalid=0.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both valids high -> all ready/rvalid/mem_valid=0; release -> m0 accepted first cycle.
- Single fetch: m0_valid, addr=0x8000_0000; mem_ready=1; rdata=0x0000_0013 one cycle after issue -> m0_rvalid at N+3, m0_rdata=0x13, m0_err=0, m1_rvalid=0.
- Contention: both valid continuously -> grants alternate m0,m1,m0,m1. Store from m1 (addr=0x8000_1000, wdata=0xDEAD_BEEF, wmask=0x0F) appears on mem_* unchanged, and mem_wen=1 only on m1 issues.
- Backpressure: mem_ready low 5 cycles -> mem_valid and mem_addr stable for 6 cycles; no second ready until RESP completes.
- Timeout: TIMEOUT=8, mem_rvalid never returns -> m1_rvalid=1 with err=1, rdata=0, exactly 8 cycles after entering WAIT. A late mem_rvalid in IDLE produces no rvalid.
- Reset mid-WAIT: rst=0 during WAIT -> IDLE next cycle, no rvalid. A new m0 request after release completes normally.
